// File: rtl/imem_fetch_arbiter.sv
// Instruction-memory port arbiter: shares one byte-wide synchronous memory
// port between the CPU fetch unit (4-byte big-endian word reads) and the
// program loader (single-byte writes), with round-robin tie breaking.
module imem_fetch_arbiter #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [31:0]       fetch_data,
  input  logic              load_req,
  input  logic [31:0]       load_addr,
  input  logic [7:0]        load_data,
  output logic              load_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_CAPTURE = 3'd2,
    S_DONE    = 3'd3,
    S_WRITE   = 3'd4
  } state_e;

  typedef enum logic {
    GRANT_LOAD  = 1'b0,
    GRANT_FETCH = 1'b1
  } grant_e;

  state_e            state_q, state_d;
  grant_e            last_grant_q, last_grant_d;
  logic [1:0]        k_q, k_d;
  logic [23:0]       shift_q, shift_d;
  logic [31:0]       fetch_data_q, fetch_data_d;
  logic              fetch_valid_q, fetch_valid_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;

  // Upper address bits are deliberately ignored (addresses wrap).
  logic unused_addr_bits_s;
  assign unused_addr_bits_s = ^{fetch_addr[31:ADDR_W], load_addr[31:ADDR_W]};

  // Accept strobes: only in IDLE, never both, tie goes to the side not granted last.
  always_comb begin
    fetch_ready = 1'b0;
    load_ready  = 1'b0;
    if (!rst && (state_q == S_IDLE)) begin
      if (fetch_req && (!load_req || (last_grant_q == GRANT_LOAD))) begin
        fetch_ready = 1'b1;
      end else if (load_req) begin
        load_ready = 1'b1;
      end else begin
        fetch_ready = 1'b0;
        load_ready  = 1'b0;
      end
    end else begin
      fetch_ready = 1'b0;
      load_ready  = 1'b0;
    end
  end

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    k_d           = k_q;
    shift_d       = shift_q;
    fetch_data_d  = fetch_data_q;
    fetch_valid_d = 1'b0;
    mem_addr_d    = {ADDR_W{1'b0}};
    mem_we_d      = 1'b0;
    mem_wdata_d   = mem_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (fetch_ready) begin
          state_d      = S_READ;
          k_d          = 2'd0;
          mem_addr_d   = fetch_addr[ADDR_W-1:0];
          last_grant_d = GRANT_FETCH;
        end else if (load_ready) begin
          state_d      = S_WRITE;
          mem_addr_d   = load_addr[ADDR_W-1:0];
          mem_we_d     = 1'b1;
          mem_wdata_d  = load_data;
          last_grant_d = GRANT_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        // Read data lags the address by one cycle, so byte k-1 arrives now.
        if (k_q != 2'd0) begin
          shift_d = {shift_q[15:0], mem_rdata};
        end else begin
          shift_d = shift_q;
        end
        if (k_q == 2'd3) begin
          state_d = S_CAPTURE;
          k_d     = 2'd0;
        end else begin
          k_d        = k_q + 2'd1;
          mem_addr_d = mem_addr_q + ADDR_W'(1'b1);
        end
      end
      S_CAPTURE: begin
        fetch_data_d  = {shift_q, mem_rdata};
        fetch_valid_d = 1'b1;
        state_d       = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_WRITE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any sequence in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      last_grant_q  <= GRANT_LOAD;
      k_q           <= 2'd0;
      shift_q       <= 24'd0;
      fetch_data_q  <= 32'd0;
      fetch_valid_q <= 1'b0;
      mem_addr_q    <= {ADDR_W{1'b0}};
      mem_we_q      <= 1'b0;
      mem_wdata_q   <= 8'd0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      k_q           <= k_d;
      shift_q       <= shift_d;
      fetch_data_q  <= fetch_data_d;
      fetch_valid_q <= fetch_valid_d;
      mem_addr_q    <= mem_addr_d;
      mem_we_q      <= mem_we_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  assign fetch_valid = fetch_valid_q;
  assign fetch_data  = fetch_data_q;
  assign mem_addr    = mem_addr_q;
  assign mem_we      = mem_we_q;
  assign mem_wdata   = mem_wdata_q;

endmodule
